// File: rtl/sm_muldiv_if.sv
// Request/result bundle between the schoolMIPS core and the iterative multiply/divide unit.
interface sm_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       oper;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             cancel;
  logic             hiWe;
  logic             loWe;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, oper, srcA, srcB, cancel, hiWe, loWe, wd,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  start, oper, srcA, srcB, cancel, hiWe, loWe, wd,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU, one bit per cycle, results held in HI/LO.
// Signed ops run on magnitudes; signs are applied when the result is written.
module sm_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  sm_muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dzo_q, dzo_d;

  logic             a_sgn, b_sgn, start_dz, last;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;
  logic [PW-1:0]    step, prod_fix;

  // Operand magnitudes and one shift-add / restoring-subtract step
  always_comb begin
    a_sgn    = bus.oper[0] & bus.srcA[WIDTH-1];
    b_sgn    = bus.oper[0] & bus.srcB[WIDTH-1];
    a_mag    = a_sgn ? (~bus.srcA + WIDTH'(1)) : bus.srcA;
    b_mag    = b_sgn ? (~bus.srcB + WIDTH'(1)) : bus.srcB;
    start_dz = bus.oper[1] & (bus.srcB == '0);

    mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : '0)};
    div_rem  = acc_q[PW-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opb_q};
    if (is_div_q) begin
      step = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod_fix = neg_q  ? (~step + PW'(1)) : step;
    quo_fix  = neg_q  ? (~step[WIDTH-1:0] + WIDTH'(1)) : step[WIDTH-1:0];
    rem_fix  = rneg_q ? (~step[PW-1:WIDTH] + WIDTH'(1)) : step[PW-1:WIDTH];
    last     = dz_q | (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dzo_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (bus.hiWe) hi_d = bus.wd;
        if (bus.loWe) lo_d = bus.wd;
        if (!bus.cancel && bus.start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = bus.oper[1];
          neg_d    = a_sgn ^ b_sgn;
          rneg_d   = a_sgn;
          dz_d     = start_dz;
          // Divide-by-zero returns the raw dividend in HI, so keep it unconverted
          opa_d    = start_dz ? bus.srcA : a_mag;
          opb_d    = b_mag;
          acc_d    = bus.oper[1] ? {WIDTH'(0), a_mag} : {WIDTH'(0), b_mag};
        end
      end
      S_RUN: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d = S_FIN;
            dzo_d   = dz_q;
            if (dz_q) begin
              lo_d = '1;
              hi_d = opa_q;
            end else if (is_div_q) begin
              lo_d = quo_fix;
              hi_d = rem_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = dzo_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_sm_muldiv.sv
// Bench for sm_muldiv: directed WIDTH=32 vectors and corner sequences, random WIDTH=8 vs an arithmetic model.
module tb_sm_muldiv;
  logic clk = 1'b0;
  logic rst32_n, rst8_n;
  always #5 clk = ~clk;

  sm_muldiv_if #(.WIDTH(32)) b32 ();
  sm_muldiv_if #(.WIDTH(8))  b8 ();
  sm_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst32_n), .bus(b32));
  sm_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst8_n),  .bus(b8));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after an edge; returns in cycle 1 with operands scrambled.
  task automatic go32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    b32.oper = op; b32.srcA = a; b32.srcB = b; b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0; b32.oper = ~op; b32.srcA = $urandom; b32.srcB = $urandom;
  endtask

  task automatic wait32(input string name, input int lat, input logic [31:0] eh,
                        input logic [31:0] el, input logic edz);
    int cyc = 1;
    bit run_ok = 1'b1;
    logic [31:0] h0 = b32.hi, l0 = b32.lo;
    while (b32.done !== 1'b1 && cyc < 100) begin
      if (b32.busy !== 1'b1 || b32.hi !== h0 || b32.lo !== l0) run_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(lat));
    check({name, " busy/stable in run"}, 64'(run_ok), 64'(1));
    check({name, " busy at done"}, 64'(b32.busy), 64'(0));
    check({name, " hi"}, 64'(b32.hi), 64'(eh));
    check({name, " lo"}, 64'(b32.lo), 64'(el));
    check({name, " divZero"}, 64'(b32.divZero), 64'(edz));
  endtask

  task automatic go8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    b8.oper = op; b8.srcA = a; b8.srcB = b; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0; b8.oper = ~op; b8.srcA = 8'($urandom); b8.srcB = 8'($urandom);
  endtask

  task automatic wait8(input int lat, input logic [7:0] eh, input logic [7:0] el, input logic edz);
    int cyc = 1;
    while (b8.done !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w8 latency", 64'(cyc), 64'(lat));
    check("w8 hi", 64'(b8.hi), 64'(eh));
    check("w8 lo", 64'(b8.lo), 64'(el));
    check("w8 divZero", 64'(b8.divZero), 64'(edz));
  endtask

  // Reference: MIPS semantics straight from integer arithmetic
  function automatic void model8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] hi, output logic [7:0] lo, output logic dz);
    int sa, sb, ua, ub, p, q, r;
    sa = $signed(a); sb = $signed(b); ua = int'(a); ub = int'(b);
    dz = 1'b0; hi = '0; lo = '0;
    case (op)
      2'd0: begin p = ua * ub; hi = p[15:8]; lo = p[7:0]; end
      2'd1: begin p = sa * sb; hi = p[15:8]; lo = p[7:0]; end
      default: begin
        if (b == 8'd0) begin
          dz = 1'b1; lo = 8'hFF; hi = a;
        end else if (op == 2'd3 && sa == -128 && sb == -1) begin
          lo = 8'h80; hi = 8'h00;
        end else begin
          if (op == 2'd2) begin q = ua / ub; r = ua % ub; end
          else            begin q = sa / sb; r = sa % sb; end
          lo = q[7:0]; hi = r[7:0];
        end
      end
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    bit seen_done;
    logic [7:0] mh, ml, ra, rb;
    logic md;

    vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[2]  = '{2'd2, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 2};
    vecs[3]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[4]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[5]  = '{2'd2, 32'h00000009, 32'h00000004, 32'h00000001, 32'h00000002, 1'b0, 33};
    vecs[6]  = '{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[8]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[9]  = '{2'd3, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1, 2};
    vecs[10] = '{2'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33};
    vecs[11] = '{2'd0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};
    vecs[12] = '{2'd2, 32'h00000005, 32'h00000007, 32'h00000005, 32'h00000000, 1'b0, 33};
    vecs[13] = '{2'd1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 33};

    {b32.start, b32.oper, b32.srcA, b32.srcB, b32.cancel, b32.hiWe, b32.loWe, b32.wd} = '0;
    {b8.start, b8.oper, b8.srcA, b8.srcB, b8.cancel, b8.hiWe, b8.loWe, b8.wd} = '0;
    rst32_n = 1'b0; rst8_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(b32.busy), 64'(0));
    check("reset done", 64'(b32.done), 64'(0));
    check("reset divZero", 64'(b32.divZero), 64'(0));
    check("reset hi", 64'(b32.hi), 64'(0));
    check("reset lo", 64'(b32.lo), 64'(0));
    rst32_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      go32(vecs[i].op, vecs[i].a, vecs[i].b);
      wait32($sformatf("vec%0d", i), vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      @(posedge clk); #1;
    end

    // Back-to-back: DIV issued in the done cycle of MULT
    go32(2'd1, 32'hFFFFFFFD, 32'd5);
    wait32("b2b mult", 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    go32(2'd3, 32'hFFFFFFF9, 32'd2);
    wait32("b2b div", 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    @(posedge clk); #1;

    // Preload, then cancel a DIVU with an ignored start and hiWe mid-run
    b32.hiWe = 1'b1; b32.wd = 32'h1111;
    @(posedge clk); #1;
    b32.hiWe = 1'b0; b32.loWe = 1'b1; b32.wd = 32'h2222;
    @(posedge clk); #1;
    b32.loWe = 1'b0;
    check("preload hi", 64'(b32.hi), 64'h1111);
    check("preload lo", 64'(b32.lo), 64'h2222);
    go32(2'd2, 32'd9, 32'd4);
    for (int c = 1; c <= 10; c++) begin
      b32.start  = (c == 5);
      b32.hiWe   = (c == 6);
      b32.wd     = 32'hDEAD;
      b32.cancel = (c == 10);
      if (c == 8) begin
        check("cancel hiWe ignored", 64'(b32.hi), 64'h1111);
        check("cancel busy mid", 64'(b32.busy), 64'(1));
      end
      @(posedge clk); #1;
    end
    b32.start = 1'b0; b32.hiWe = 1'b0; b32.cancel = 1'b0;
    check("cancel busy drop", 64'(b32.busy), 64'(0));
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b32.done === 1'b1) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    check("cancel no done", 64'(seen_done), 64'(0));
    check("cancel hi kept", 64'(b32.hi), 64'h1111);
    check("cancel lo kept", 64'(b32.lo), 64'h2222);

    // Reset in cycle 15 of a MULTU, then rerun it
    go32(2'd0, 32'd7, 32'd6);
    repeat (14) begin @(posedge clk); #1; end
    rst32_n = 1'b0;
    @(posedge clk); #1;
    check("midrst busy", 64'(b32.busy), 64'(0));
    check("midrst done", 64'(b32.done), 64'(0));
    check("midrst divZero", 64'(b32.divZero), 64'(0));
    check("midrst hi", 64'(b32.hi), 64'(0));
    check("midrst lo", 64'(b32.lo), 64'(0));
    rst32_n = 1'b1;
    @(posedge clk); #1;
    go32(2'd0, 32'd7, 32'd6);
    wait32("after reset", 33, 32'd0, 32'd42, 1'b0);

    // WIDTH=8 random sweep against the model
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if (op >= 2 && (i % 16) == 0) rb = 8'h00;
        if (op == 3 && (i % 32) == 1) begin ra = 8'h80; rb = 8'hFF; end
        if (op == 1 && (i % 32) == 2) begin ra = 8'h80; rb = 8'h80; end
        model8(2'(op), ra, rb, mh, ml, md);
        go8(2'(op), ra, rb);
        wait8(md ? 2 : 9, mh, ml, md);
        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sm_muldiv.md
# sm_muldiv

Iterative multiply/divide unit for the schoolMIPS core, the parametrised, multi-cycle successor to the single-cycle ALU `MUL` path. It runs MIPS-style `MULT`/`MULTU`/`DIV`/`DIVU` over `WIDTH` cycles, one bit per cycle, and holds results in architectural `HI`/`LO` registers. `HI` and `LO` can also be written directly (`MTHI`/`MTLO`). The core stalls on `busy`, and `cancel` aborts an operation on pipeline flush.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width. Must be ≥ 4.
- `clk` in, 1: clock. All state changes on the rising edge.
- `rst_n` in, 1: reset. Synchronous, active-low.
- `start` in, 1: request an operation. Sampled only when `busy`=0.
- `oper` in, 2: operation select. 0=MULTU, 1=MULT, 2=DIVU, 3=DIV. Sampled with `start`.
- `srcA` in, WIDTH: multiplicand or dividend. Sampled with `start`.
- `srcB` in, WIDTH: multiplier or divisor. Sampled with `start`.
- `cancel` in, 1: abort the running operation.
- `hiWe` in, 1: direct write of `wd` into HI.
- `loWe` in, 1: direct write of `wd` into LO.
- `wd` in, WIDTH: data for direct HI/LO writes.
- `busy` out, 1: operation in progress. The core must stall dependent MFHI/MFLO reads.
- `done` out, 1: one-cycle pulse; HI/LO hold the new result.
- `divZero` out, 1: valid while `done`=1; the divisor was zero.
- `hi` out, WIDTH: HI register.
- `lo` out, WIDTH: LO register.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: iteration counter 0..WIDTH-1.
  - FIN: one cycle, `done`=1, `busy`=0.
- FSM transitions:
  - IDLE→RUN on `start`.
  - RUN→FIN when the counter reaches WIDTH-1, or after 1 cycle when the divisor is zero.
  - FIN→RUN if `start`, else FIN→IDLE.
  - Any state→IDLE on `cancel`.
- Signed ops:
  - Operands are converted to magnitudes at start; result signs are recorded.
  - Signs are fixed up at the final edge.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Multiply:
  - Shift-add, 2·WIDTH-bit product.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide:
  - Restoring shift-subtract.
  - LO = quotient, HI = remainder.
- Divide by zero:
  - LO = all ones, HI = `srcA` unchanged, `divZero`=1.
  - No trap is raised.
- Signed overflow (DIV of most-negative by -1): LO = most-negative, HI = 0, no flag.
- Operand registers hold the sampled values, so `srcA`, `srcB` and `oper` may change after the start cycle.
- `start` while `busy`=1: ignored. There is no queue.
- `cancel`:
  - Has priority over `start` in the same cycle.
  - HI/LO keep their pre-operation values, and no `done` follows.
  - When idle it has no effect.
- `hiWe`/`loWe`:
  - Honoured only when `busy`=0; ignored while busy.
  - May coincide with an accepted `start`: the write lands first, and the operation result later overwrites it.
- FIN result write has priority over `hiWe`/`loWe` in the same cycle. This cannot occur, since both are busy-gated; the bench asserts it.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State→IDLE.
  - `busy`=0, `done`=0, `divZero`=0, `hi`=0, `lo`=0.
  - Applies mid-operation; the partial result is discarded.
- Normal latency:
  - `start` sampled at edge of cycle 0.
  - `busy`=1 in cycles 1..WIDTH.
  - HI/LO written at the edge ending cycle WIDTH.
  - `done`=1 and `busy`=0 in cycle WIDTH+1.
  - Total WIDTH+1 cycles from request to `done`.
- Divide-by-zero latency:
  - `busy`=1 in cycle 1 only.
  - `done` and `divZero`=1 in cycle 2.
- Back-to-back:
  - `start` in the `done` cycle is accepted.
  - `busy` rises again in the next cycle; there are no dead cycles.
- `cancel` sampled in cycle k of RUN: `busy`=0 from cycle k+1.
- Direct writes: `hi`/`lo` reflect `wd` in the cycle after `hiWe`/`loWe`.
- `hi`/`lo` are stable throughout RUN: they show old values until the final edge.

## Test plan
- MULTU `srcA`=`srcB`=0xFFFFFFFF (WIDTH=32) → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` in cycle 33, `busy` high cycles 1–32.
- MULT -3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then back-to-back DIV -7/2 started in the `done` cycle → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100/0 → `done`+`divZero` in cycle 2, `lo`=0xFFFFFFFF, `hi`=0x00000064. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `divZero`=0.
- Preload `hiWe`/`loWe` 0x1111/0x2222, then start DIVU 9/4:
  - Assert `cancel` in cycle 10 → `busy`=0 in cycle 11, no `done`, `hi`/`lo` remain 0x1111/0x2222.
  - A `start` pulsed in cycle 5 is ignored.
  - `hiWe` in cycle 6 is ignored.
- Start MULTU 7×6, drive `rst_n`=0 in cycle 15 → all outputs 0 in cycle 16. A new MULTU 7×6 → `lo`=42, `hi`=0.
- Parameter sweep WIDTH=8, random 1000 ops per `oper` against a reference model:
  - Exact HI/LO.
  - Latency 9 cycles, or 2 cycles for divide by zero.
